// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the MIPS datapath.
// master: the controller (consumes IR fields, drives control levels).
// slave:  the datapath side (presents IR fields, consumes control levels).
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             run;
  logic [5:0]       op;
  logic [5:0]       func;
  logic             ir_wr;
  logic             pc_wr;
  logic             RegWr;
  logic             ExtOp;
  logic [2:0]       ALUctr;
  logic             ALUsrc;
  logic             MemWr;
  logic             RegDst;
  logic             MemtoReg;
  logic             branch;
  logic             jump;
  logic [2:0]       state;
  logic             illegal;
  logic             instr_done;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, op, func,
    output ir_wr, pc_wr, RegWr, ExtOp, ALUctr, ALUsrc, MemWr, RegDst, MemtoReg,
           branch, jump, state, illegal, instr_done, retired
  );

  modport slave (
    output run, op, func,
    input  ir_wr, pc_wr, RegWr, ExtOp, ALUctr, ALUsrc, MemWr, RegDst, MemtoReg,
           branch, jump, state, illegal, instr_done, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore controller for the multicycle single-issue MIPS datapath.
// Sequences IF/ID/EXE/MEM/WB, latches op/func on leaving ID, counts retired
// instructions and parks in HALT on an unsupported encoding.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StExe  = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsR, ClsAddiu, ClsOri, ClsLw, ClsSw, ClsBeq, ClsJ, ClsBad
  } cls_e;

  // Instruction class from the op/func fields; ClsBad for anything unsupported.
  function automatic cls_e classify(input logic [5:0] op_f, input logic [5:0] func_f);
    cls_e c;
    case (op_f)
      6'b000000: begin
        case (func_f)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b101010: c = ClsR;
          default:                         c = ClsBad;
        endcase
      end
      6'b001001: c = ClsAddiu;
      6'b001101: c = ClsOri;
      6'b100011: c = ClsLw;
      6'b101011: c = ClsSw;
      6'b000100: c = ClsBeq;
      6'b000010: c = ClsJ;
      default:   c = ClsBad;
    endcase
    return c;
  endfunction

  // ALU operation for a supported R-type func.
  function automatic logic [2:0] r_aluctr(input logic [5:0] func_f);
    logic [2:0] a;
    case (func_f)
      6'b100010, 6'b100011: a = 3'b001;
      6'b100100:            a = 3'b010;
      6'b100101:            a = 3'b011;
      6'b101010:            a = 3'b100;
      default:              a = 3'b000;
    endcase
    return a;
  endfunction

  state_e           state_q;
  logic [5:0]       op_q;
  logic [5:0]       func_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  cls_e cls_id;   // live fields, only meaningful in ID
  cls_e cls_q;    // latched fields, used from EXE onwards
  logic done;

  assign cls_id = classify(bus.op, bus.func);
  assign cls_q  = classify(op_q, func_q);

  // State sequencing, IR field latch, sticky illegal flag and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIf;
      op_q      <= 6'b0;
      func_q    <= 6'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (done) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      case (state_q)
        StIf: begin
          if (bus.run) begin
            state_q <= StId;
          end
        end
        StId: begin
          op_q   <= bus.op;
          func_q <= bus.func;
          if (cls_id == ClsJ) begin
            state_q <= StIf;
          end else if (cls_id == ClsBad) begin
            state_q   <= StHalt;
            illegal_q <= 1'b1;
          end else begin
            state_q <= StExe;
          end
        end
        StExe: begin
          if (cls_q == ClsBeq) begin
            state_q <= StIf;
          end else if (cls_q == ClsLw || cls_q == ClsSw) begin
            state_q <= StMem;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          state_q <= (cls_q == ClsLw) ? StWb : StIf;
        end
        StWb: begin
          state_q <= StIf;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIf;
        end
      endcase
    end
  end

  // Control outputs decoded from the current state and the latched fields;
  // only IF (run) and ID (jump decode) look at live inputs.
  always_comb begin
    bus.ir_wr    = 1'b0;
    bus.pc_wr    = 1'b0;
    bus.RegWr    = 1'b0;
    bus.ExtOp    = 1'b0;
    bus.ALUctr   = 3'b000;
    bus.ALUsrc   = 1'b0;
    bus.MemWr    = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.branch   = 1'b0;
    bus.jump     = 1'b0;
    done         = 1'b0;

    // ALU-side levels are held identically through EXE, MEM and WB.
    if (state_q == StExe || state_q == StMem || state_q == StWb) begin
      case (cls_q)
        ClsR: begin
          bus.ALUctr = r_aluctr(func_q);
          bus.RegDst = 1'b1;
        end
        ClsAddiu, ClsLw, ClsSw: begin
          bus.ALUsrc = 1'b1;
          bus.ExtOp  = 1'b1;
        end
        ClsOri: begin
          bus.ALUsrc = 1'b1;
          bus.ALUctr = 3'b011;
        end
        ClsBeq: begin
          bus.ALUctr = 3'b001;
        end
        default: ;
      endcase
    end

    case (state_q)
      // rst_n gate keeps ir_wr low while reset holds the FSM in IF.
      StIf: bus.ir_wr = bus.run & rst_n;
      StId: begin
        if (cls_id == ClsJ) begin
          bus.jump  = 1'b1;
          bus.pc_wr = 1'b1;
          done      = 1'b1;
        end
      end
      StExe: begin
        if (cls_q == ClsBeq) begin
          bus.branch = 1'b1;
          bus.pc_wr  = 1'b1;
          done       = 1'b1;
        end
      end
      StMem: begin
        if (cls_q == ClsSw) begin
          bus.MemWr = 1'b1;
          bus.pc_wr = 1'b1;
          done      = 1'b1;
        end
      end
      StWb: begin
        bus.RegWr    = 1'b1;
        bus.pc_wr    = 1'b1;
        bus.MemtoReg = (cls_q == ClsLw);
        done         = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.instr_done = done;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal_q;
  assign bus.retired    = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM that sequences the single-issue MIPS datapath (IFU, register file, ALU, data memory) over multiple cycles per instruction.
- Decodes the op/func fields the datapath returns and drives the datapath control inputs: RegWr, ExtOp, ALUctr, ALUsrc, MemWr, RegDst, MemtoReg, branch, jump.
- Adds the enables a multicycle datapath needs: pc_wr and ir_wr.
- Counts retired instructions and halts on unsupported encodings.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
run  input  1  permits fetch of a new instruction
op  input  6  instruction[31:26] from datapath IR
func  input  6  instruction[5:0] from datapath IR
ir_wr  output  1  load instruction register
pc_wr  output  1  PC update enable (PC+4, branch or jump target)
RegWr  output  1  register file write enable
ExtOp  output  1  1 = sign-extend imm16, 0 = zero-extend
ALUctr  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
ALUsrc  output  1  1 = imm32, 0 = busB
MemWr  output  1  data memory write enable
RegDst  output  1  1 = Rd, 0 = Rt
MemtoReg  output  1  1 = memory data, 0 = ALU result
branch  output  1  PC select: beq target when zero
jump  output  1  PC select: jump target
state  output  3  current FSM state
illegal  output  1  sticky; unsupported op/func decoded
instr_done  output  1  one-cycle pulse in the last state of each instruction
retired  output  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset: state=IF and all outputs 0, including retired and illegal. Asserting rst_n mid-instruction aborts it immediately; RegWr, MemWr and pc_wr drop asynchronously.
- State encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
- Latch: op and func are captured into internal registers on the ID->next edge. Decode in EXE, MEM and WB uses only the latched copies.
- Supported instructions:
  - R-type (op 000000): func 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 101010 slt.
  - addiu 001001, ori 001101, lw 100011, sw 101011, beq 000100, j 000010.
- IF: if run=1, assert ir_wr and go to ID. If run=0, stay in IF with all enables 0 (idle, no count).
- ID:
  - j: assert jump and pc_wr, pulse instr_done, go to IF.
  - Unsupported op, or R-type with unsupported func: go to HALT.
  - Otherwise go to EXE.
- EXE (control levels per class):
  - R-type: ALUsrc=0, RegDst=1, ALUctr from func.
  - addiu: ALUsrc=1, ExtOp=1, ALUctr=000.
  - ori: ALUsrc=1, ExtOp=0, ALUctr=011.
  - lw/sw: ALUsrc=1, ExtOp=1, ALUctr=000.
  - beq: ALUsrc=0, ALUctr=001, branch=1, pc_wr=1, instr_done=1; go to IF.
  - R-type/addiu/ori go to WB; lw/sw go to MEM.
- MEM: ALU controls held as in EXE.
  - sw: MemWr=1, pc_wr=1, instr_done=1; go to IF.
  - lw: go to WB.
- WB: ALU/ExtOp/ALUsrc/RegDst held as in EXE. MemtoReg=1 for lw only. Assert RegWr, pc_wr and instr_done; go to IF.
- Control levels: ALUctr, ALUsrc, ExtOp and RegDst remain stable from EXE through WB for the same instruction. RegWr and MemWr are never asserted outside WB and MEM respectively.
- pc_wr: exactly one cycle per retired instruction. branch and jump are asserted only in the cycle that pc_wr is asserted.
- Cycle counts: j 2, beq 3, R/addiu/ori 4, sw 4, lw 5.
- retired: increments on every instr_done cycle and wraps at 2^CNT_W-1 -> 0.
- HALT: illegal=1 (sticky) and all enables 0. HALT is terminal until rst_n is asserted; run is ignored.
- Outputs are decoded from state and the latched op/func only (Moore): no combinational path from run, op or func to any output except in IF/ID as specified.

Test Plan:
- Reset: hold rst_n=0, drive op/func with random values -> state=0, all outputs 0, retired=0. Release with run=0 -> FSM stays in IF, ir_wr=0.
- R-type sequence: run=1, op=000000, func=100010 -> states 0,1,2,4. ALUctr=001 and RegDst=1 in cycles 3-4. RegWr=1 and pc_wr=1 in cycle 4 only. retired=1.
- Load/store: lw (100011) -> 5 cycles, MemtoReg=1 and RegWr=1 in WB, MemWr=0 throughout. sw (101011) -> 4 cycles, MemWr=1 in MEM only, RegWr never 1.
- Control transfer: beq (000100) -> 3 cycles, branch=pc_wr=1 in EXE, ALUctr=001. j (000010) -> 2 cycles, jump=pc_wr=1 in ID. retired increments by 1 each.
- Illegal: op=111111, or R-type func=000000 -> HALT (state=5), illegal=1, no further ir_wr/pc_wr for 20 cycles with run=1. Asserting rst_n clears to IF.
- Reset mid-instruction and wrap: rst_n=0 during lw MEM -> immediate return to IF, RegWr never asserted. With CNT_W=2, 4 retirements -> retired=0.
